// File: rtl/evm_pkg.sv
// Shared types for the EVM vote tally: ballot FSM states and mode encodings.
package evm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ACK   = 2'd2,
        LOCK  = 2'd3
    } state_t;

    localparam logic MODE_VOTE   = 1'b0;
    localparam logic MODE_RESULT = 1'b1;

endpackage

// File: rtl/ballot_tally_if.sv
// Board-side bundle of the tally core: officer controls, buttons, and LED/status outputs.
interface ballot_tally_if #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8
);
    localparam int IDX_W = $clog2(NUM_CAND);

    logic                mode;
    logic                arm;
    logic [NUM_CAND-1:0] buttons;
    logic                ready;
    logic                vote_ack;
    logic [CNT_W-1:0]    leds;
    logic [IDX_W-1:0]    winner_idx;
    logic                tie;
    logic                sat;

    modport master (
        output mode, arm, buttons,
        input  ready, vote_ack, leds, winner_idx, tie, sat
    );

    modport slave (
        input  mode, arm, buttons,
        output ready, vote_ack, leds, winner_idx, tie, sat
    );

endinterface

// File: rtl/btn_debounce.sv
// Per-button debouncer: a press pulses once, the cycle after DEBOUNCE consecutive high samples.
module btn_debounce #(
    parameter int DEBOUNCE = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int            CW      = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

    logic [CW-1:0] cnt;
    logic          fired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            fired <= 1'b0;
            press <= 1'b0;
        end else begin
            if (!btn)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CW'(1);
            press <= (cnt == CNT_MAX) && !fired;
            // fired holds off a second pulse until the button is released
            fired <= btn && (fired || (cnt == CNT_MAX));
        end
    end

endmodule

// File: rtl/ballot_tally.sv
// N-candidate vote tally: one vote per armed ballot, saturating counts, winner/tie scan, LED mux.
//   state | meaning
//   IDLE  | no ballot armed; presses ignored
//   ARMED | ballot open, waiting for exactly one press
//   ACK   | vote counted; leds all-ones for ACK_CYC cycles
//   LOCK  | waiting for every button to be released
module ballot_tally #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int DEBOUNCE = 10,
    parameter int ACK_CYC  = 4
) (
    input logic           clk,
    input logic           reset,
    ballot_tally_if.slave bus
);
    import evm_pkg::*;

    localparam int               IDX_W    = $clog2(NUM_CAND);
    localparam int               TW       = $clog2(ACK_CYC + 1);
    localparam logic [TW-1:0]    ACK_LOAD = TW'(ACK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [NUM_CAND-1:0] press;
    logic [IDX_W-1:0]    press_idx;
    state_t              state;
    state_t              state_nxt;
    logic                vote_fire;
    logic [TW-1:0]       ack_tmr;
    logic [CNT_W-1:0]    count [NUM_CAND];
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_valid;
    logic [CNT_W-1:0]    best;
    logic [IDX_W-1:0]    best_idx;
    logic                best_tie;

    for (genvar g = 0; g < NUM_CAND; g++) begin : gen_db
        btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
            .clk   (clk),
            .reset (reset),
            .btn   (bus.buttons[g]),
            .press (press[g])
        );
    end

    always_comb begin
        press_idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--)
            if (press[i]) press_idx = IDX_W'(i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        vote_fire = 1'b0;
        if (bus.mode == MODE_RESULT) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (bus.arm) state_nxt = ARMED;
                ARMED: if ($onehot(press)) begin
                    vote_fire = 1'b1;
                    state_nxt = ACK;
                end
                ACK:   if (ack_tmr == '0) state_nxt = LOCK;
                LOCK:  if (bus.buttons == '0) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ack_tmr <= '0;
        else if (vote_fire)
            ack_tmr <= ACK_LOAD;
        else if (state == ACK && ack_tmr != '0)
            ack_tmr <= ack_tmr - TW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CAND; i++) count[i] <= '0;
            bus.vote_ack <= 1'b0;
            bus.sat      <= 1'b0;
        end else begin
            bus.vote_ack <= vote_fire;
            if (vote_fire) begin
                if (count[press_idx] == CNT_MAX)
                    bus.sat <= 1'b1;
                else
                    count[press_idx] <= count[press_idx] + CNT_W'(1);
            end
        end
    end

    // Result-mode selection is forgotten whenever we return to vote mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_idx   <= '0;
            sel_valid <= 1'b0;
        end else if (bus.mode == MODE_VOTE) begin
            sel_valid <= 1'b0;
        end else if (|press) begin
            sel_idx   <= press_idx;
            sel_valid <= 1'b1;
        end
    end

    always_comb begin
        best     = count[0];
        best_idx = '0;
        best_tie = 1'b0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (count[i] > best) begin
                best     = count[i];
                best_idx = IDX_W'(i);
                best_tie = 1'b0;
            end else if (count[i] == best && best != '0) begin
                best_tie = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.winner_idx <= '0;
            bus.tie        <= 1'b0;
        end else begin
            bus.winner_idx <= best_idx;
            bus.tie        <= best_tie;
        end
    end

    assign bus.ready = (state == ARMED);

    always_comb begin
        bus.leds = '0;
        if (bus.mode == MODE_RESULT) begin
            if (sel_valid) bus.leds = count[sel_idx];
        end else if (state == ACK) begin
            bus.leds = '1;
        end
    end

endmodule
